// File: rtl/seg_scan_driver_if.sv
// Display-side signal bundle for seg_scan_driver: number/mode in, scanned segments out.
// The controller side (master) drives value/mode; the driver (slave) drives seg/an/busy.
interface seg_scan_driver_if;
  logic [15:0] value;
  logic        dec_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  modport master (
    output value, dec_mode, blank_lz,
    input  seg, an, busy
  );

  modport slave (
    input  value, dec_mode, blank_lz,
    output seg, an, busy
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode seven-segment scan driver with hex or double-dabble decimal
// rendering, optional leading-zero blanking and atomic display update.
//
// state | meaning
// IDLE  | compare input against captured copy, capture on change
// CONV  | 16 double-dabble iterations, one per clk
// LOAD  | write display nibbles, overflow flag and leading-zero mask
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int SCAN_W      = 17
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t             state;
  logic [15:0]        cap_value;
  logic               cap_dec;
  logic [19:0]        bcd;
  logic [15:0]        bin;
  logic [3:0]         iter;
  logic [15:0]        disp_dig;
  logic [3:0]         lz_mask;
  logic               disp_ovf;
  logic [SCAN_W-1:0]  presc;
  logic [1:0]         idx;
  logic [6:0]         seg_q;
  logic [3:0]         an_q;
  logic               busy_q;

  logic [19:0]        bcd_adj;
  logic [15:0]        load_dig;
  logic               load_ovf;
  logic [3:0]         load_lz;
  logic [3:0]         cur_nib;
  logic               cur_blank;
  logic [6:0]         next_seg;
  logic [3:0]         next_an;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Decimal overflow (ten-thousands nibble set) forces dashes and disables blanking.
  always_comb begin
    load_dig = cap_dec ? bcd[15:0] : cap_value;
    load_ovf = cap_dec & (|bcd[19:16]);
    load_lz  = 4'b0000;
    load_lz[3] = (load_dig[15:12] == 4'd0);
    load_lz[2] = load_lz[3] & (load_dig[11:8] == 4'd0);
    load_lz[1] = load_lz[2] & (load_dig[7:4] == 4'd0);
    if (load_ovf) load_lz = 4'b0000;
  end

  always_comb begin
    case (idx)
      2'd0:    cur_nib = disp_dig[3:0];
      2'd1:    cur_nib = disp_dig[7:4];
      2'd2:    cur_nib = disp_dig[11:8];
      default: cur_nib = disp_dig[15:12];
    endcase
    cur_blank = bus.blank_lz & lz_mask[idx] & ~disp_ovf;
    next_seg  = cur_blank ? 7'h7F : (disp_ovf ? 7'h3F : seg_code(cur_nib));
    next_an   = cur_blank ? 4'hF : ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cap_value <= 16'd0;
      cap_dec   <= 1'b0;
      bcd       <= 20'd0;
      bin       <= 16'd0;
      iter      <= 4'd0;
      disp_dig  <= 16'd0;
      lz_mask   <= 4'b0000;
      disp_ovf  <= 1'b0;
      presc     <= '0;
      idx       <= 2'd0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
      busy_q    <= 1'b0;
    end else begin
      if (presc == SCAN_W'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg_q <= next_seg;
      an_q  <= next_an;

      case (state)
        IDLE: begin
          if ({bus.value, bus.dec_mode} != {cap_value, cap_dec}) begin
            cap_value <= bus.value;
            cap_dec   <= bus.dec_mode;
            busy_q    <= 1'b1;
            if (bus.dec_mode) begin
              state <= CONV;
              bcd   <= 20'd0;
              bin   <= bus.value;
              iter  <= 4'd0;
            end else begin
              state <= LOAD;
            end
          end
        end
        CONV: begin
          bcd  <= {bcd_adj[18:0], bin[15]};
          bin  <= {bin[14:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= LOAD;
        end
        LOAD: begin
          disp_dig <= load_dig;
          disp_ovf <= load_ovf;
          lz_mask  <= load_lz;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;

endmodule
